// File: rtl/tl_phase_sched.sv
// Two-road intersection phase scheduler: green/yellow/all-red sequencing with
// vehicle sensors, latched pedestrian requests and an emergency override.
module tl_phase_sched #(
    parameter int unsigned GMIN = 5,
    parameter int unsigned GMAX = 20,
    parameter int unsigned YEL  = 3,
    parameter int unsigned ARD  = 1,
    parameter int unsigned WALK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Pa,
    input  logic       Pb,
    input  logic       emg,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk_a,
    output logic       walk_b,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_AG  = 3'd0,
        S_AY  = 3'd1,
        S_AR  = 3'd2,
        S_BG  = 3'd3,
        S_BY  = 3'd4,
        S_BR  = 3'd5,
        S_EMG = 3'd6
    } state_t;

    localparam logic [1:0] L_GRN = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_RED = 2'b10;

    // Limits expressed as cycle counts, compared against timer+1 (cycles spent in state).
    localparam logic [8:0] C_GMIN = 9'(GMIN);
    localparam logic [8:0] C_GMAX = 9'(GMAX);
    localparam logic [8:0] C_YEL  = 9'(YEL);
    localparam logic [8:0] C_ARD  = 9'(ARD);
    localparam logic [7:0] C_WALK = 8'(WALK);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_timer;
    logic       r_req_a;
    logic       r_req_b;
    logic       r_walk_en_a;
    logic       r_walk_en_b;
    logic       r_ar_home;
    logic [8:0] w_elapsed;
    logic       w_sw_a;
    logic       w_sw_b;
    logic       w_change;
    logic       w_enter_ag;
    logic       w_enter_bg;

    assign w_elapsed  = {1'b0, r_timer} + 9'd1;
    assign w_sw_a     = Ta | r_req_a;
    assign w_sw_b     = Tb | r_req_b;
    assign w_change   = (w_next != r_state);
    assign w_enter_ag = w_change && (w_next == S_AG);
    assign w_enter_bg = w_change && (w_next == S_BG);

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_AG: begin
                if (emg || ((w_elapsed >= C_GMIN) && w_sw_b && (!Ta || (w_elapsed >= C_GMAX))))
                    w_next = S_AY;
            end
            S_AY: begin
                if (w_elapsed >= C_YEL)
                    w_next = emg ? S_EMG : S_AR;
            end
            S_AR: begin
                if (emg)
                    w_next = S_EMG;
                else if (w_elapsed >= C_ARD)
                    w_next = r_ar_home ? S_AG : S_BG;
            end
            S_BG: begin
                if (emg || ((w_elapsed >= C_GMIN) && w_sw_a && (!Tb || (w_elapsed >= C_GMAX))))
                    w_next = S_BY;
            end
            S_BY: begin
                if (w_elapsed >= C_YEL)
                    w_next = emg ? S_EMG : S_BR;
            end
            S_BR: begin
                if (emg)
                    w_next = S_EMG;
                else if (w_elapsed >= C_ARD)
                    w_next = S_AG;
            end
            S_EMG: begin
                if (!emg)
                    w_next = S_AR;
            end
            default: w_next = S_AG;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_AG;
            r_timer     <= 8'd0;
            r_req_a     <= 1'b0;
            r_req_b     <= 1'b0;
            r_walk_en_a <= 1'b0;
            r_walk_en_b <= 1'b0;
            r_ar_home   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_change)
                r_timer <= 8'd0;
            else if (r_timer != 8'hFF)
                r_timer <= r_timer + 8'd1;

            // Entry into a green grants walk from the held latch and clears it, beating a new request.
            if (w_enter_ag) begin
                r_walk_en_a <= r_req_a;
                r_req_a     <= 1'b0;
            end else if (Pa) begin
                r_req_a <= 1'b1;
            end

            if (w_enter_bg) begin
                r_walk_en_b <= r_req_b;
                r_req_b     <= 1'b0;
            end else if (Pb) begin
                r_req_b <= 1'b1;
            end

            // All-red reached from EMG returns to road A rather than handing over to B.
            if (w_change)
                r_ar_home <= (r_state == S_EMG);
        end
    end

    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (r_state)
            S_AG:    La = L_GRN;
            S_AY:    La = L_YEL;
            S_BG:    Lb = L_GRN;
            S_BY:    Lb = L_YEL;
            default: ;
        endcase
    end

    assign walk_a = (r_state == S_AG) && r_walk_en_a && (r_timer < C_WALK);
    assign walk_b = (r_state == S_BG) && r_walk_en_b && (r_timer < C_WALK);
    assign phase  = r_state;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Scoreboard bench for tl_phase_sched: directed stimulus pushes hand-computed
// expected phase/walk per cycle; a monitor pops and compares after each edge.
module tb_tl_phase_sched;

    localparam logic [2:0] AG  = 3'd0;
    localparam logic [2:0] AY  = 3'd1;
    localparam logic [2:0] AR  = 3'd2;
    localparam logic [2:0] BG  = 3'd3;
    localparam logic [2:0] BY  = 3'd4;
    localparam logic [2:0] BR  = 3'd5;
    localparam logic [2:0] EMG = 3'd6;

    typedef struct packed {
        logic [2:0] ph;
        logic       wa;
        logic       wb;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       Ta, Tb, Pa, Pb, emg;
    logic [1:0] La, Lb;
    logic       walk_a, walk_b;
    logic [2:0] phase;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string tname = "init";

    tl_phase_sched dut (
        .clk    (clk),
        .reset  (reset),
        .Ta     (Ta),
        .Tb     (Tb),
        .Pa     (Pa),
        .Pb     (Pb),
        .emg    (emg),
        .La     (La),
        .Lb     (Lb),
        .walk_a (walk_a),
        .walk_b (walk_b),
        .phase  (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp encoding per phase: {La, Lb}.
    function automatic logic [3:0] lights(input logic [2:0] ph);
        case (ph)
            AG:      return 4'b00_10;
            AY:      return 4'b01_10;
            BG:      return 4'b10_00;
            BY:      return 4'b10_01;
            default: return 4'b10_10;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%s] at %0t: got %h, expected %h", name, tname, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ta, input logic tb, input logic pa,
                        input logic pb, input logic e, input logic [2:0] ph,
                        input logic wa, input logic wb);
        exp_t x;
        @(negedge clk);
        reset = rst; Ta = ta; Tb = tb; Pa = pa; Pb = pb; emg = e;
        x.ph = ph; x.wa = wa; x.wb = wb;
        q.push_back(x);
    endtask

    task automatic run(input int n, input logic rst, input logic ta, input logic tb,
                       input logic pa, input logic pb, input logic e,
                       input logic [2:0] ph, input logic wa, input logic wb);
        for (int i = 0; i < n; i++) step(rst, ta, tb, pa, pb, e, ph, wa, wb);
    endtask

    // Monitor: every edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("outputs", {7'd0, phase, La, Lb, walk_a, walk_b},
                      {7'd0, e.ph, lights(e.ph), e.wa, e.wb});
                check("no_dual_green", {15'd0, (La == 2'b00) && (Lb == 2'b00)}, 16'd0);
            end
        end
    end

    initial begin
        reset = 1'b1; Ta = 0; Tb = 0; Pa = 0; Pb = 0; emg = 0;
        #1 reset = 1'b0;
        #1 check("reset_state", {7'd0, phase, La, Lb, walk_a, walk_b}, {7'd0, AG, 4'b0010, 2'b00});

        // Idle: no traffic, A green holds forever.
        tname = "idle";
        run(100, 1, 0, 0, 0, 0, 0, AG, 0, 0);

        // Tb only: 5 AG, 3 AY, 1 AR, BG on the 9th edge after release.
        tname = "tb_only";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(4, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, BG, 0, 0);

        // Both roads busy: greens last GMAX, two full cycles.
        tname = "gmax";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(19, 1, 1, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 1, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 1, 1, 0, 0, 0, AR, 0, 0);
        run(20, 1, 1, 1, 0, 0, 0, BG, 0, 0);
        run(3, 1, 1, 1, 0, 0, 0, BY, 0, 0);
        run(1, 1, 1, 1, 0, 0, 0, BR, 0, 0);
        run(20, 1, 1, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 1, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 1, 1, 0, 0, 0, AR, 0, 0);
        run(20, 1, 1, 1, 0, 0, 0, BG, 0, 0);
        run(3, 1, 1, 1, 0, 0, 0, BY, 0, 0);
        run(1, 1, 1, 1, 0, 0, 0, BR, 0, 0);
        run(1, 1, 1, 1, 0, 0, 0, AG, 0, 0);

        // Pedestrian A pulse during BG: switch after GMIN, walk_a 4 cycles, latch cleared.
        tname = "ped_a";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(4, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(1, 1, 0, 0, 0, 0, 0, BG, 0, 0);
        step(1, 0, 0, 1, 0, 0, BG, 0, 0);
        run(3, 1, 0, 0, 0, 0, 0, BG, 0, 0);
        run(3, 1, 0, 0, 0, 0, 0, BY, 0, 0);
        run(1, 1, 0, 0, 0, 0, 0, BR, 0, 0);
        run(4, 1, 0, 0, 0, 0, 0, AG, 1, 0);
        run(6, 1, 0, 0, 0, 0, 0, AG, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(2, 1, 0, 0, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 0, 0, 0, 0, AR, 0, 0);
        run(10, 1, 0, 0, 0, 0, 0, BG, 0, 0);

        // Emergency at AG timer 2: yellow completes, EMG, then AR back to AG.
        tname = "emg_ag";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(2, 1, 0, 0, 0, 0, 0, AG, 0, 0);
        run(1, 1, 0, 0, 0, 0, 1, AY, 0, 0);
        run(2, 1, 0, 0, 0, 0, 1, AY, 0, 0);
        run(5, 1, 0, 0, 0, 0, 1, EMG, 0, 0);
        run(1, 1, 0, 0, 0, 0, 0, AR, 0, 0);
        run(4, 1, 0, 0, 0, 0, 0, AG, 0, 0);

        // Emergency during all-red: EMG next cycle, recovery returns to A.
        tname = "emg_ar";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(4, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(1, 1, 0, 1, 0, 0, 1, EMG, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(5, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AY, 0, 0);

        // Pedestrian B walk, then reset mid-BY forces AG at once.
        tname = "rst_by";
        run(2, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        step(1, 0, 1, 0, 1, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(4, 1, 1, 0, 0, 0, 0, BG, 0, 1);
        run(1, 1, 1, 0, 0, 0, 0, BG, 0, 0);
        run(2, 1, 1, 0, 0, 0, 0, BY, 0, 0);
        step(0, 0, 0, 0, 0, 0, AG, 0, 0);
        #1 check("async_reset", {7'd0, phase, La, Lb, walk_a, walk_b}, {7'd0, AG, 4'b0010, 2'b00});
        run(1, 0, 0, 0, 0, 0, 0, AG, 0, 0);
        run(4, 1, 0, 1, 0, 0, 0, AG, 0, 0);
        run(3, 1, 0, 1, 0, 0, 0, AY, 0, 0);
        run(1, 1, 0, 1, 0, 0, 0, AR, 0, 0);
        run(2, 1, 0, 1, 0, 0, 0, BG, 0, 0);

        tname = "drain";
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        check("queue_drained", 16'(q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
- Phase scheduler for the two-road intersection: A road and B road.
- Sequences green, yellow and all-red phases using programmable cycle timers.
- Honours the road sensors Ta/Tb, latched pedestrian requests and an emergency override.
- Drives the A-road and B-road light outputs and the walk indications; sits between the sensor inputs and the lamp drivers.

Parameters:
- GMIN, 5, minimum green length in cycles (1..GMAX)
- GMAX, 20, maximum green length in cycles when the crossing road is waiting (GMIN..255)
- YEL, 3, yellow length in cycles (>=1)
- ARD, 1, all-red clearance length in cycles (>=1)
- WALK, 4, walk-signal length in cycles (1..GMIN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- Ta  input  1  vehicle present on road A
- Tb  input  1  vehicle present on road B
- Pa  input  1  pedestrian request, served during A green (level, sampled each cycle)
- Pb  input  1  pedestrian request, served during B green
- emg  input  1  emergency override, level
- La  output  2  road A light: 00 green, 01 yellow, 10 red
- Lb  output  2  road B light, same encoding
- walk_a  output  1  walk indication concurrent with A green
- walk_b  output  1  walk indication concurrent with B green
- phase  output  3  state: 0 AG, 1 AY, 2 AR, 3 BG, 4 BY, 5 BR, 6 EMG

Behaviour:
- Timer and latches: 8-bit timer cleared on every state change, incremented otherwise, saturating at 255. req_a and req_b are pedestrian latches.
- Reset (reset=0, asynchronous):
  - state AG, timer 0, req_a=req_b=0.
  - Outputs La=00, Lb=10, walk_a=walk_b=0, phase=0.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Pedestrian latches:
  - req_x sets in any cycle Px=1.
  - req_x clears on the cycle the state enters x-green; the walk window is granted from the latch value held at entry.
  - Clear wins over a simultaneous set on the entry cycle. Px held high through entry re-latches on the next cycle and is served on the next x-green.
- Walk: walk_x=1 for the first WALK cycles of x-green (timer 0..WALK-1), only if req_x was 1 at entry; otherwise 0.
- AG (La=00, Lb=10):
  - Define sw_b = Tb | req_b.
  - Go to AY when timer>=GMIN-1 and sw_b and (~Ta or timer>=GMAX-1).
  - With sw_b=0, remain in AG indefinitely.
- AY (La=01, Lb=10): exactly YEL cycles, then AR.
- AR (La=10, Lb=10): exactly ARD cycles, then BG.
- BG, BY, BR mirror AG, AY, AR with roles swapped; BR exits to AG.
- Emergency:
  - emg=1 in AG or BG: go to that road's yellow next cycle, ignoring GMIN and walk.
  - emg=1 in a yellow: the yellow completes its YEL cycles, then go to EMG instead of all-red.
  - emg=1 in AR or BR: go to EMG next cycle.
  - EMG: La=Lb=10, walk outputs 0, latches keep accumulating. Held while emg=1.
  - emg=0 in EMG: go to AR for ARD cycles, then AG (road A priority).
- Greens must never be simultaneous. A green is only entered from all-red, and a road's light never goes directly from green to red.
- Reset asserted mid-phase forces AG immediately; timer and latches are cleared.

Test Plan:
- Reset release, Ta=0, Tb=0, no requests, 100 cycles:
  - phase stays 0, La=00, Lb=10.
- Reset release, then Tb=1 (Ta=0):
  - AG for 5 cycles, AY for 3, AR for 1, then BG (phase 3, La=10, Lb=00).
  - Exactly 9 cycles from reset release to BG.
- Ta=1 and Tb=1 held:
  - AG lasts 20 cycles (GMAX), then AY.
  - BG also lasts 20 cycles before BY.
  - Repeat two full cycles; La and Lb are never both 00.
- Pulse Pa=1 for 1 cycle during BG with Ta=0, Tb=0:
  - BG ends after GMIN (req_a acts as switch request).
  - On AG entry, walk_a=1 for 4 cycles, then 0; req_a is cleared.
- emg=1 at AG timer=2:
  - next cycle AY (3 cycles), then EMG with La=Lb=10 while emg=1.
  - On emg=0: AR 1 cycle, then AG.
- Reset pulled low during BY:
  - immediately phase=0, La=00, Lb=10, walk outputs 0.
  - After release, normal sequencing resumes from timer 0.
